// File: rtl/flofifo_wr_arb_pkg.sv
// Shared parameters and helpers for the flofifo multi-source write arbiter.
package flofifo_wr_arb_pkg;

  localparam int unsigned N_SRC_DEF  = 4;
  localparam int unsigned WIDTH_DEF  = 24;
  localparam int unsigned LENGTH_DEF = 32;
  localparam int unsigned CNTW_DEF   = 8;

  // Fill level at or above which no new grant may issue; one slot is kept for the registered write.
  function automatic int unsigned headroom_limit(input int unsigned length);
    return length - 2;
  endfunction

endpackage

// File: rtl/flofifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, modulo N_SRC.
module flofifo_wr_arb_rr_pick #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDW-1:0]   ptr,
  input  logic             en,
  output logic [N_SRC-1:0] gnt_onehot,
  output logic [IDW-1:0]   gnt_idx,
  output logic             valid
);

  int unsigned j;
  logic [IDW-1:0] jj;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    valid      = 1'b0;
    j          = 0;
    jj         = '0;
    for (int unsigned i = 1; i <= N_SRC; i++) begin
      j  = (32'(ptr) + i) % N_SRC;
      jj = IDW'(j);
      if (en && !valid && req[jj]) begin
        valid          = 1'b1;
        gnt_idx        = jj;
        gnt_onehot[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flofifo_wr_arb.sv
// Round-robin write arbiter sharing one flofifo among N_SRC sources with
// one-deep holding registers, source-ID tagging and per-source drop counters.
module flofifo_wr_arb
  import flofifo_wr_arb_pkg::*;
#(
  parameter  int unsigned N_SRC  = N_SRC_DEF,
  parameter  int unsigned WIDTH  = WIDTH_DEF,
  parameter  int unsigned LENGTH = LENGTH_DEF,
  parameter  int unsigned CNTW   = CNTW_DEF,
  localparam int unsigned IDW    = $clog2(N_SRC),
  localparam int unsigned PW     = WIDTH - IDW,
  localparam int unsigned LOCW   = $clog2(LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic                  clear_i,
  input  logic [N_SRC*PW-1:0]   src_data_i,
  input  logic [N_SRC-1:0]      src_valid_i,
  input  logic                  fifo_full_i,
  input  logic [LOCW-1:0]       fifo_locs_i,
  output logic [WIDTH-1:0]      fifo_data_o,
  output logic                  fifo_valid_o,
  output logic [N_SRC-1:0]      pending_o,
  output logic [N_SRC-1:0]      ovf_o,
  output logic [N_SRC*CNTW-1:0] drop_cnt_o
);

  logic [PW-1:0]    hold [N_SRC];
  logic [CNTW-1:0]  cnt  [N_SRC];
  logic [IDW-1:0]   ptr;
  logic             permit_c;
  logic [N_SRC-1:0] gnt_onehot;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_valid;

  assign permit_c = en_i && !fifo_full_i &&
                    (fifo_locs_i < LOCW'(headroom_limit(LENGTH)));

  flofifo_wr_arb_rr_pick #(
    .N_SRC (N_SRC),
    .IDW   (IDW)
  ) u_pick (
    .req        (pending_o),
    .ptr        (ptr),
    .en         (permit_c),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .valid      (gnt_valid)
  );

  for (genvar k = 0; k < N_SRC; k++) begin : g_cnt
    assign drop_cnt_o[k*CNTW +: CNTW] = cnt[k];
  end

  // Holding registers, drop accounting, RR pointer and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_valid_o <= 1'b0;
      fifo_data_o  <= '0;
      pending_o    <= '0;
      ovf_o        <= '0;
      ptr          <= IDW'(N_SRC - 1);
      for (int k = 0; k < N_SRC; k++) begin
        hold[k] <= '0;
        cnt[k]  <= '0;
      end
    end else if (clear_i) begin
      fifo_valid_o <= 1'b0;
      fifo_data_o  <= '0;
      pending_o    <= '0;
      ovf_o        <= '0;
      ptr          <= IDW'(N_SRC - 1);
      for (int k = 0; k < N_SRC; k++) begin
        hold[k] <= '0;
        cnt[k]  <= '0;
      end
    end else begin
      fifo_valid_o <= gnt_valid;
      if (gnt_valid) begin
        fifo_data_o <= {gnt_idx, hold[gnt_idx]};
        ptr         <= gnt_idx;
      end
      for (int k = 0; k < N_SRC; k++) begin
        if (src_valid_i[k]) begin
          // A slot being drained this cycle can accept the new sample without loss.
          if (!pending_o[k] || gnt_onehot[k]) begin
            hold[k]      <= src_data_i[k*PW +: PW];
            pending_o[k] <= 1'b1;
          end else begin
            ovf_o[k] <= 1'b1;
            if (cnt[k] != '1) cnt[k] <= cnt[k] + CNTW'(1);
          end
        end else if (gnt_onehot[k]) begin
          pending_o[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_flofifo_wr_arb.sv
// Directed self-checking bench for flofifo_wr_arb (N_SRC=4, WIDTH=24, LENGTH=32, CNTW=8).
module tb_flofifo_wr_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 24;
  localparam int unsigned PW = 22;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          clear;
  logic [N*PW-1:0] src_data;
  logic [N-1:0]  src_valid;
  logic          full;
  logic [4:0]    locs;
  logic [W-1:0]  fdata;
  logic          fvalid;
  logic [N-1:0]  pending;
  logic [N-1:0]  ovf;
  logic [N*CW-1:0] dcnt;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_d;

  flofifo_wr_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .clear_i      (clear),
    .src_data_i   (src_data),
    .src_valid_i  (src_valid),
    .fifo_full_i  (full),
    .fifo_locs_i  (locs),
    .fifo_data_o  (fdata),
    .fifo_valid_o (fvalid),
    .pending_o    (pending),
    .ovf_o        (ovf),
    .drop_cnt_o   (dcnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; clear = 1'b0; src_data = '0; src_valid = '0;
    full = 1'b0; locs = 5'd0;
    tick(); tick();
    tests++;
    if ({fvalid, fdata, pending, ovf, dcnt} !== '0) begin
      fails++;
      $display("FAIL reset: valid=%b data=%h pend=%b ovf=%b cnt=%h, want all 0",
               fvalid, fdata, pending, ovf, dcnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    src_valid = 4'b0100; src_data[2*PW +: PW] = 22'h001234;
    tick();
    src_valid = '0;
    tests++;
    if (pending !== 4'b0100 || fvalid !== 1'b0) begin
      fails++; $display("FAIL single_capture: pend=%b valid=%b, want 0100/0", pending, fvalid);
    end
    tick();
    exp_d = {2'd2, 22'h001234};
    tests++;
    if (fvalid !== 1'b1 || fdata !== exp_d || pending !== 4'b0000) begin
      fails++; $display("FAIL single_write: valid=%b data=%h pend=%b, want 1/%h/0000",
                        fvalid, fdata, pending, exp_d);
    end
    tick();
    tests++;
    if (fvalid !== 1'b0 || fdata !== exp_d) begin
      fails++; $display("FAIL single_idle: valid=%b data=%h, want 0/%h held", fvalid, fdata, exp_d);
    end
  endtask

  task automatic test_round_robin();
    do_clear();
    src_valid = 4'b1111;
    for (int k = 0; k < 4; k++) src_data[k*PW +: PW] = PW'(10 + k);
    tick();
    src_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_d = {2'(k), PW'(10 + k)};
      tests++;
      if (fvalid !== 1'b1 || fdata !== exp_d) begin
        fails++; $display("FAIL rr_burst%0d: valid=%b data=%h, want 1/%h", k, fvalid, fdata, exp_d);
      end
    end
    tick();
    tests++;
    if (fvalid !== 1'b0 || pending !== 4'b0000) begin
      fails++; $display("FAIL rr_drain: valid=%b pend=%b, want 0/0000", fvalid, pending);
    end
    // Move the pointer to source 0, then contend 0 vs 1.
    src_valid = 4'b0001; src_data[0 +: PW] = PW'(20);
    tick();
    src_valid = '0;
    tick();
    exp_d = {2'd0, 22'd20};
    tests++;
    if (fvalid !== 1'b1 || fdata !== exp_d) begin
      fails++; $display("FAIL rr_src0: valid=%b data=%h, want 1/%h", fvalid, fdata, exp_d);
    end
    src_valid = 4'b0011; src_data[0 +: PW] = PW'(21); src_data[PW +: PW] = PW'(31);
    tick();
    src_valid = '0;
    tick();
    exp_d = {2'd1, 22'd31};
    tests++;
    if (fvalid !== 1'b1 || fdata !== exp_d) begin
      fails++; $display("FAIL rr_first: valid=%b data=%h, want 1/%h", fvalid, fdata, exp_d);
    end
    tick();
    exp_d = {2'd0, 22'd21};
    tests++;
    if (fvalid !== 1'b1 || fdata !== exp_d) begin
      fails++; $display("FAIL rr_second: valid=%b data=%h, want 1/%h", fvalid, fdata, exp_d);
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_clear();
    src_valid = 4'b0010; src_data[PW +: PW] = PW'(39);
    tick();
    src_valid = '0;
    tick();
    locs = 5'd30;
    src_valid = 4'b0111;
    for (int k = 0; k < 3; k++) src_data[k*PW +: PW] = PW'(40 + k);
    tick();
    src_valid = '0;
    tick(); tick();
    tests++;
    if (fvalid !== 1'b0 || pending !== 4'b0111) begin
      fails++; $display("FAIL bp_locs30: valid=%b pend=%b, want 0/0111", fvalid, pending);
    end
    locs = 5'd0; full = 1'b1;
    tick(); tick();
    tests++;
    if (fvalid !== 1'b0 || pending !== 4'b0111) begin
      fails++; $display("FAIL bp_full: valid=%b pend=%b, want 0/0111", fvalid, pending);
    end
    full = 1'b0; locs = 5'd29;
    for (int n = 0; n < 3; n++) begin
      tick();
      exp_d = (n == 0) ? {2'd2, 22'd42} : (n == 1) ? {2'd0, 22'd40} : {2'd1, 22'd41};
      tests++;
      if (fvalid !== 1'b1 || fdata !== exp_d) begin
        fails++; $display("FAIL bp_resume%0d: valid=%b data=%h, want 1/%h", n, fvalid, fdata, exp_d);
      end
    end
    locs = 5'd0;
    tick();
  endtask

  task automatic test_overflow();
    do_clear();
    en = 1'b0;
    for (int n = 0; n < 5; n++) begin
      src_valid = 4'b1000; src_data[3*PW +: PW] = PW'(50 + n);
      tick();
    end
    src_valid = '0;
    tests++;
    if (pending !== 4'b1000 || ovf !== 4'b1000 || dcnt[3*CW +: CW] !== 8'd4 || fvalid !== 1'b0) begin
      fails++; $display("FAIL ovf_flags: pend=%b ovf=%b cnt3=%0d valid=%b, want 1000/1000/4/0",
                        pending, ovf, dcnt[3*CW +: CW], fvalid);
    end
    en = 1'b1;
    tick();
    exp_d = {2'd3, 22'd50};
    tests++;
    if (fvalid !== 1'b1 || fdata !== exp_d) begin
      fails++; $display("FAIL ovf_write: valid=%b data=%h, want 1/%h", fvalid, fdata, exp_d);
    end
    tick();
    tests++;
    if (fvalid !== 1'b0 || pending !== 4'b0000) begin
      fails++; $display("FAIL ovf_single: valid=%b pend=%b, want 0/0000", fvalid, pending);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    en = 1'b0;
    src_valid = 4'b0001;
    for (int n = 0; n < 300; n++) tick();
    src_valid = '0;
    tests++;
    if (dcnt[0 +: CW] !== 8'd255 || ovf !== 4'b0001) begin
      fails++; $display("FAIL sat_cnt: cnt0=%0d ovf=%b, want 255/0001", dcnt[0 +: CW], ovf);
    end
    en = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_clear();
    src_valid = 4'b0001; src_data[0 +: PW] = PW'(60);
    tick();
    src_data[0 +: PW] = PW'(61);
    tick();
    src_valid = '0;
    exp_d = {2'd0, 22'd60};
    tests++;
    if (fvalid !== 1'b1 || fdata !== exp_d || pending !== 4'b0001 || ovf !== 4'b0000) begin
      fails++; $display("FAIL b2b_first: valid=%b data=%h pend=%b ovf=%b, want 1/%h/0001/0000",
                        fvalid, fdata, pending, ovf, exp_d);
    end
    tick();
    exp_d = {2'd0, 22'd61};
    tests++;
    if (fvalid !== 1'b1 || fdata !== exp_d) begin
      fails++; $display("FAIL b2b_second: valid=%b data=%h, want 1/%h", fvalid, fdata, exp_d);
    end
    tick();
    tests++;
    if (fvalid !== 1'b0 || pending !== 4'b0000 || dcnt !== '0) begin
      fails++; $display("FAIL b2b_end: valid=%b pend=%b cnt=%h, want 0/0000/0", fvalid, pending, dcnt);
    end
  endtask

  task automatic test_clear();
    do_clear();
    en = 1'b0;
    src_valid = 4'b0100; src_data[2*PW +: PW] = PW'(70);
    tick();
    src_data[2*PW +: PW] = PW'(71);
    tick();
    tests++;
    if (pending !== 4'b0100 || ovf !== 4'b0100 || dcnt[2*CW +: CW] !== 8'd1) begin
      fails++; $display("FAIL clr_setup: pend=%b ovf=%b cnt2=%0d, want 0100/0100/1",
                        pending, ovf, dcnt[2*CW +: CW]);
    end
    en = 1'b1; clear = 1'b1;
    src_valid = 4'b0010; src_data[PW +: PW] = PW'(80);
    tick();
    clear = 1'b0; src_valid = '0;
    tests++;
    if ({fvalid, fdata, pending, ovf, dcnt} !== '0) begin
      fails++; $display("FAIL clr_state: valid=%b data=%h pend=%b ovf=%b cnt=%h, want all 0",
                        fvalid, fdata, pending, ovf, dcnt);
    end
    tick();
    tests++;
    if (fvalid !== 1'b0 || pending !== 4'b0000) begin
      fails++; $display("FAIL clr_ignored: valid=%b pend=%b, want 0/0000", fvalid, pending);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_clear();
    src_valid = 4'b1111;
    for (int k = 0; k < 4; k++) src_data[k*PW +: PW] = PW'(90 + k);
    tick();
    src_valid = '0;
    tick();
    exp_d = {2'd0, 22'd90};
    tests++;
    if (fvalid !== 1'b1 || fdata !== exp_d) begin
      fails++; $display("FAIL rst_pre: valid=%b data=%h, want 1/%h", fvalid, fdata, exp_d);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({fvalid, fdata, pending, ovf, dcnt} !== '0) begin
      fails++; $display("FAIL rst_async: valid=%b data=%h pend=%b ovf=%b cnt=%h, want all 0",
                        fvalid, fdata, pending, ovf, dcnt);
    end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    tests++;
    if (fvalid !== 1'b0 || pending !== 4'b0000) begin
      fails++; $display("FAIL rst_after: valid=%b pend=%b, want 0/0000", fvalid, pending);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_saturation();
    test_back_to_back();
    test_clear();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
